// File: rtl/op_encode_if.sv
// op_encode_if: request side and byte-stream side handshake bundle for op_encode.
// The slave modport is the encoder; the master modport is whoever issues
// requests and consumes the emitted bytes.
interface op_encode_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_mnem;
  logic [3:0]  in_mode;
  logic [15:0] in_operand;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        err;

  modport slave (
    input  in_valid, in_mnem, in_mode, in_operand, out_ready,
    output in_ready, out_valid, out_byte, out_last, err
  );

  modport master (
    output in_valid, in_mnem, in_mode, in_operand, out_ready,
    input  in_ready, out_valid, out_byte, out_last, err
  );
endinterface

// File: rtl/op_encode.sv
// op_encode: turns a {group, aaa} mnemonic plus addressing mode and operand
// into a 6502-style byte stream (opcode, operand low, operand high).
// Optional feature macro: ENC_LEGAL_CHECK_EN. When defined, illegal
// mnemonic/mode combinations are rejected with a one-cycle err pulse.
// When undefined, err stays 0 and every request is encoded straight from
// the bbb tables; modes with no table entry give bbb=000 and a 1-byte
// instruction (grp00 IND always encodes as 6C, grp11 non-IMP as {aaa,000,11}).
module op_encode (
  input  logic       clk,
  input  logic       rst,
  op_encode_if.slave bus
);

  localparam logic [3:0] MODE_IMP = 4'd0;
  localparam logic [3:0] MODE_ACC = 4'd1;
  localparam logic [3:0] MODE_IMM = 4'd2;
  localparam logic [3:0] MODE_ZPG = 4'd3;
  localparam logic [3:0] MODE_ZPX = 4'd4;
  localparam logic [3:0] MODE_ZPY = 4'd5;
  localparam logic [3:0] MODE_ABS = 4'd6;
  localparam logic [3:0] MODE_ABX = 4'd7;
  localparam logic [3:0] MODE_ABY = 4'd8;
  localparam logic [3:0] MODE_IND = 4'd9;
  localparam logic [3:0] MODE_XIN = 4'd10;
  localparam logic [3:0] MODE_INY = 4'd11;
  localparam logic [3:0] MODE_REL = 4'd12;

  localparam logic [1:0] GRP_CTL = 2'b00;
  localparam logic [1:0] GRP_ALU = 2'b01;
  localparam logic [1:0] GRP_RMW = 2'b10;
  localparam logic [1:0] GRP_RAW = 2'b11;

`ifdef ENC_LEGAL_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPC  = 2'd1,
    ST_LO   = 2'd2,
    ST_HI   = 2'd3
  } state_t;

  // request decode
  logic [1:0] grp_s;
  logic [2:0] aaa_s;
  logic [2:0] aaa_enc_s;
  logic [2:0] bbb_s;
  logic       mapped_s;
  logic       legal_s;
  logic       raw_s;
  logic       illegal_s;
  logic [1:0] len_mode_s;
  logic [1:0] len_s;
  logic [7:0] opcode_s;

  // sequencer state and registered outputs
  state_t     state_q, state_d;
  logic [7:0] lo_q, lo_d;
  logic [7:0] hi_q, hi_d;
  logic [1:0] len_q, len_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] out_byte_q, out_byte_d;
  logic       out_last_q, out_last_d;
  logic       err_q, err_d;
  logic       in_ready_q, in_ready_d;

  // Map mnemonic group and addressing mode onto opcode fields and legality.
  always_comb begin
    grp_s     = bus.in_mnem[4:3];
    aaa_s     = bus.in_mnem[2:0];
    aaa_enc_s = aaa_s;
    bbb_s     = 3'b000;
    mapped_s  = 1'b1;
    legal_s   = 1'b1;
    raw_s     = 1'b0;
    case (grp_s)
      GRP_ALU: begin
        case (bus.in_mode)
          MODE_XIN: bbb_s = 3'b000;
          MODE_ZPG: bbb_s = 3'b001;
          MODE_IMM: begin
            bbb_s   = 3'b010;
            legal_s = (aaa_s != 3'b100);  // no store-immediate
          end
          MODE_ABS: bbb_s = 3'b011;
          MODE_INY: bbb_s = 3'b100;
          MODE_ZPX: bbb_s = 3'b101;
          MODE_ABY: bbb_s = 3'b110;
          MODE_ABX: bbb_s = 3'b111;
          default: begin
            mapped_s = 1'b0;
            legal_s  = 1'b0;
          end
        endcase
      end
      GRP_RMW: begin
        // aaa 100/101 (STX/LDX) index with Y; the rest index with X
        case (bus.in_mode)
          MODE_IMM: begin
            bbb_s   = 3'b000;
            legal_s = (aaa_s == 3'b101);
          end
          MODE_ZPG: bbb_s = 3'b001;
          MODE_ACC: begin
            bbb_s   = 3'b010;
            legal_s = ~aaa_s[2];
          end
          MODE_ABS: bbb_s = 3'b011;
          MODE_ZPX: begin
            bbb_s   = 3'b101;
            legal_s = (aaa_s[2:1] != 2'b10);
          end
          MODE_ZPY: begin
            bbb_s   = 3'b101;
            legal_s = (aaa_s[2:1] == 2'b10);
          end
          MODE_ABX: begin
            bbb_s   = 3'b111;
            legal_s = (aaa_s[2:1] != 2'b10);
          end
          MODE_ABY: begin
            bbb_s   = 3'b111;
            legal_s = (aaa_s == 3'b101);
          end
          default: begin
            mapped_s = 1'b0;
            legal_s  = 1'b0;
          end
        endcase
      end
      GRP_CTL: begin
        case (bus.in_mode)
          MODE_REL: bbb_s = 3'b100;
          MODE_IND: begin
            // JMP (ind) lives at 6C, i.e. aaa field 011
            aaa_enc_s = 3'b011;
            bbb_s     = 3'b011;
            legal_s   = (aaa_s == 3'b010);
          end
          MODE_IMM: begin
            bbb_s   = 3'b000;
            legal_s = (aaa_s inside {3'b101, 3'b110, 3'b111});
          end
          MODE_ZPG: begin
            bbb_s   = 3'b001;
            legal_s = (aaa_s inside {3'b001, 3'b100, 3'b101, 3'b110, 3'b111});
          end
          MODE_ZPX: begin
            bbb_s   = 3'b101;
            legal_s = (aaa_s inside {3'b100, 3'b101});
          end
          MODE_ABS: begin
            bbb_s   = 3'b011;
            legal_s = !(aaa_s inside {3'b000, 3'b011});
          end
          MODE_ABX: begin
            bbb_s   = 3'b111;
            legal_s = (aaa_s == 3'b101);
          end
          default: begin
            mapped_s = 1'b0;
            legal_s  = 1'b0;
          end
        endcase
      end
      GRP_RAW: begin
        if (bus.in_mode == MODE_IMP) begin
          raw_s = 1'b1;
        end else begin
          mapped_s = 1'b0;
          legal_s  = 1'b0;
        end
      end
      default: begin
        mapped_s = 1'b0;
        legal_s  = 1'b0;
      end
    endcase
  end

  // Instruction length from addressing mode; unmapped forms are single byte.
  always_comb begin
    case (bus.in_mode)
      MODE_IMP, MODE_ACC:                     len_mode_s = 2'd1;
      MODE_IMM, MODE_ZPG, MODE_ZPX, MODE_ZPY,
      MODE_XIN, MODE_INY, MODE_REL:           len_mode_s = 2'd2;
      MODE_ABS, MODE_ABX, MODE_ABY, MODE_IND: len_mode_s = 2'd3;
      default:                                len_mode_s = 2'd1;
    endcase
    len_s     = mapped_s ? len_mode_s : 2'd1;
    opcode_s  = raw_s ? bus.in_operand[7:0] : {aaa_enc_s, bbb_s, grp_s};
    illegal_s = CHECK_EN & ~legal_s;
  end

  // Sequencer next state: accept in IDLE, then walk opcode/low/high bytes.
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    len_d       = len_q;
    out_valid_d = out_valid_q;
    out_byte_d  = out_byte_q;
    out_last_d  = out_last_q;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (illegal_s) begin
            err_d = 1'b1;
          end else begin
            state_d     = ST_OPC;
            lo_d        = bus.in_operand[7:0];
            hi_d        = bus.in_operand[15:8];
            len_d       = len_s;
            out_valid_d = 1'b1;
            out_byte_d  = opcode_s;
            out_last_d  = (len_s == 2'd1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OPC: begin
        if (bus.out_ready) begin
          if (len_q != 2'd1) begin
            state_d    = ST_LO;
            out_byte_d = lo_q;
            out_last_d = (len_q == 2'd2);
          end else begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_byte_d  = 8'h00;
            out_last_d  = 1'b0;
          end
        end else begin
          state_d = ST_OPC;
        end
      end
      ST_LO: begin
        if (bus.out_ready) begin
          if (len_q == 2'd3) begin
            state_d    = ST_HI;
            out_byte_d = hi_q;
            out_last_d = 1'b1;
          end else begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_byte_d  = 8'h00;
            out_last_d  = 1'b0;
          end
        end else begin
          state_d = ST_LO;
        end
      end
      ST_HI: begin
        if (bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          out_byte_d  = 8'h00;
          out_last_d  = 1'b0;
        end else begin
          state_d = ST_HI;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_byte_d  = 8'h00;
        out_last_d  = 1'b0;
      end
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset drops any partial instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lo_q        <= 8'h00;
      hi_q        <= 8'h00;
      len_q       <= 2'd1;
      out_valid_q <= 1'b0;
      out_byte_q  <= 8'h00;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_byte  = out_byte_q;
  assign bus.out_last  = out_last_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_op_encode.sv
// tb_op_encode: randomized requests and back-pressure against a table-driven
// model of the encoder, plus directed sequences with literal expectations.
module tb_op_encode;

`ifdef ENC_LEGAL_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  // bbb per [group][mode]; -1 = no table entry (grp00 IND and grp11 IMP special)
  localparam int BBB_TAB [0:3][0:15] = '{
    '{-1, -1,  0,  1,  5, -1,  3,  7, -1, -1, -1, -1,  4, -1, -1, -1},
    '{-1, -1,  2,  1,  5, -1,  3,  7,  6, -1,  0,  4, -1, -1, -1, -1},
    '{-1,  2,  0,  1,  5,  5,  3,  7,  7, -1, -1, -1, -1, -1, -1, -1},
    '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1}
  };
  localparam int LEN_TAB [0:15] = '{1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 2, 2, 2, 1, 1, 1};
  // legal modes as a bit set (bit = mode number) per [group][aaa]
  localparam logic [15:0] LEGAL_MASK [0:3][0:7] = '{
    '{16'h1000, 16'h1048, 16'h1240, 16'h1000, 16'h1058, 16'h10DC, 16'h104C, 16'h104C},
    '{16'h0DDC, 16'h0DDC, 16'h0DDC, 16'h0DDC, 16'h0DD8, 16'h0DDC, 16'h0DDC, 16'h0DDC},
    '{16'h00DA, 16'h00DA, 16'h00DA, 16'h00DA, 16'h0068, 16'h016C, 16'h00D8, 16'h00D8},
    '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001}
  };

  logic clk;
  logic rst;
  op_encode_if bus ();

  op_encode dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] exp_q [$];   // {last, byte} still to be emitted
  logic       err_exp = 1'b0;
  logic [8:0] log_q [$];   // observed transfers for directed checks
  logic [31:0] r;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Returns instruction length, 0 when the request must be rejected.
  function automatic int model_encode(input logic [4:0] mnem, input logic [3:0] mode,
                                      input logic [15:0] opd, output logic [7:0] b0,
                                      output logic [7:0] b1, output logic [7:0] b2);
    logic [1:0] g;
    logic [2:0] a;
    int         bbb;
    logic [2:0] bbb3;
    g    = mnem[4:3];
    a    = mnem[2:0];
    b0   = 8'h00;
    b1   = opd[7:0];
    b2   = opd[15:8];
    bbb  = BBB_TAB[g][mode];
    bbb3 = bbb[2:0];
    if (CHECK_EN && !LEGAL_MASK[g][a][mode]) return 0;
    if (g == 2'd3 && mode == 4'd0) begin
      b0 = opd[7:0];
      return 1;
    end
    if (g == 2'd0 && mode == 4'd9) begin
      b0 = 8'h6C;
      return 3;
    end
    if (bbb < 0) begin
      b0 = {a, 3'b000, g};
      return 1;
    end
    b0 = {a, bbb3, g};
    return LEN_TAB[mode];
  endfunction

  // Reference model: advances with the clock using only the bench's own inputs.
  always @(posedge clk) begin : model
    int         n;
    logic [7:0] b0, b1, b2;
    logic       idle;
    if (rst) begin
      exp_q.delete();
      err_exp = 1'b0;
    end else begin
      idle    = (exp_q.size() == 0);
      err_exp = 1'b0;
      if (!idle && bus.out_ready) void'(exp_q.pop_front());
      if (idle && bus.in_valid) begin
        n = model_encode(bus.in_mnem, bus.in_mode, bus.in_operand, b0, b1, b2);
        if (n == 0) begin
          err_exp = 1'b1;
        end else begin
          exp_q.push_back({n == 1, b0});
          if (n >= 2) exp_q.push_back({n == 2, b1});
          if (n == 3) exp_q.push_back({1'b1, b2});
        end
      end
    end
  end

  // Transfer monitor for the directed sequences.
  always @(posedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) log_q.push_back({bus.out_last, bus.out_byte});
  end

  // Cycle-by-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk1("in_ready", bus.in_ready, exp_q.size() == 0);
      chk1("out_valid", bus.out_valid, exp_q.size() != 0);
      chk1("err", bus.err, err_exp);
      if (exp_q.size() != 0) begin
        chk8("out_byte", bus.out_byte, exp_q[0][7:0]);
        chk1("out_last", bus.out_last, exp_q[0][8]);
      end
    end
  end

  task automatic randomize_dont_care();
    r = $urandom;
    bus.in_mnem    = r[4:0];
    bus.in_mode    = r[8:5];
    bus.in_operand = r[31:16];
  endtask

  // Present one request at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [4:0] m, input logic [3:0] md, input logic [15:0] op,
                      input bit rnd);
    bit done;
    done           = 1'b0;
    bus.in_mnem    = m;
    bus.in_mode    = md;
    bus.in_operand = op;
    bus.in_valid   = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      if (rnd) begin
        r = $urandom;
        bus.out_ready = (r[1:0] != 2'b00);
      end
      if (bus.in_ready) begin
        @(posedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    chk1("send_accept_in_time", done, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    randomize_dont_care();
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      if (exp_q.size() == 0) done = 1'b1;
      else @(negedge clk);
    end
    chk1("drain_in_time", done, 1'b1);
    @(negedge clk);
  endtask

  task automatic check_log(input string name, input int n, input logic [8:0] e0,
                           input logic [8:0] e1, input logic [8:0] e2);
    logic [8:0] e [3];
    e[0] = e0;
    e[1] = e1;
    e[2] = e2;
    chki({name, "_count"}, log_q.size(), n);
    for (int i = 0; i < n && i < log_q.size(); i++) begin
      chk8({name, "_byte"}, log_q[i][7:0], e[i][7:0]);
      chk1({name, "_last"}, log_q[i][8], e[i][8]);
    end
    log_q.delete();
  endtask

  task automatic pin(input string name, input logic [4:0] m, input logic [3:0] md,
                     input logic [15:0] op, input int len, input logic [7:0] e0,
                     input logic [7:0] e1, input logic [7:0] e2);
    logic [7:0] b0, b1, b2;
    int n;
    n = model_encode(m, md, op, b0, b1, b2);
    chki({name, "_len"}, n, len);
    if (len >= 1) chk8({name, "_b0"}, b0, e0);
    if (len >= 2) chk8({name, "_b1"}, b1, e1);
    if (len >= 3) chk8({name, "_b2"}, b2, e2);
  endtask

  initial begin
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_mnem    = 5'd0;
    bus.in_mode    = 4'd0;
    bus.in_operand = 16'h0000;
    bus.out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    chk1("rst_in_ready", bus.in_ready, 1'b1);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk1("rst_out_last", bus.out_last, 1'b0);
    chk1("rst_err", bus.err, 1'b0);
    chk8("rst_out_byte", bus.out_byte, 8'h00);
    rst = 1'b0;

    // literal pins on the model itself
    pin("pin_lda_imm", 5'b01101, 4'd2, 16'h0042, 2, 8'hA9, 8'h42, 8'h00);
    pin("pin_jmp_ind", 5'b00010, 4'd9, 16'hFFFC, 3, 8'h6C, 8'hFC, 8'hFF);
    pin("pin_asl_acc", 5'b10000, 4'd1, 16'h0000, 1, 8'h0A, 8'h00, 8'h00);
    pin("pin_bne_rel", 5'b00110, 4'd12, 16'h0005, 2, 8'hD0, 8'h05, 8'h00);
    pin("pin_ldx_zpy", 5'b10101, 4'd5, 16'h0010, 2, 8'hB6, 8'h10, 8'h00);
    pin("pin_raw_imp", 5'b11000, 4'd0, 16'h00EA, 1, 8'hEA, 8'h00, 8'h00);
`ifdef ENC_LEGAL_CHECK_EN
    pin("pin_sta_imm", 5'b01100, 4'd2, 16'h0077, 0, 8'h00, 8'h00, 8'h00);
`else
    pin("pin_sta_imm", 5'b01100, 4'd2, 16'h0077, 2, 8'h89, 8'h77, 8'h00);
`endif

    // LDA IMM with continuous ready
    bus.out_ready = 1'b1;
    log_q.delete();
    send(5'b01101, 4'd2, 16'h0042, 1'b0);
    wait_idle();
    check_log("lda_imm", 2, 9'h0A9, 9'h142, 9'h000);

    // STA ABX with the second byte held for three cycles
    send(5'b01100, 4'd7, 16'h1234, 1'b0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk8("sta_abx_hold_byte", bus.out_byte, 8'h34);
      chk1("sta_abx_hold_valid", bus.out_valid, 1'b1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    wait_idle();
    check_log("sta_abx", 3, 9'h09D, 9'h034, 9'h112);

    // ASL ACC then JMP IND
    send(5'b10000, 4'd1, 16'h0000, 1'b0);
    wait_idle();
    check_log("asl_acc", 1, 9'h10A, 9'h000, 9'h000);
    send(5'b00010, 4'd9, 16'hFFFC, 1'b0);
    wait_idle();
    check_log("jmp_ind", 3, 9'h06C, 9'h0FC, 9'h1FF);

    // STA IMM
    send(5'b01100, 4'd2, 16'h0077, 1'b0);
`ifdef ENC_LEGAL_CHECK_EN
    chk1("sta_imm_err", bus.err, 1'b1);
    chk1("sta_imm_valid", bus.out_valid, 1'b0);
    chk1("sta_imm_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    chk1("sta_imm_err_end", bus.err, 1'b0);
    check_log("sta_imm", 0, 9'h000, 9'h000, 9'h000);
`else
    wait_idle();
    check_log("sta_imm", 2, 9'h089, 9'h177, 9'h000);
`endif

    // reset after the first byte of LDA ABS, then BNE REL
    send(5'b01101, 4'd6, 16'h1234, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk1("midrst_out_valid", bus.out_valid, 1'b0);
    chk1("midrst_out_last", bus.out_last, 1'b0);
    chk1("midrst_err", bus.err, 1'b0);
    chk8("midrst_out_byte", bus.out_byte, 8'h00);
    chk1("midrst_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    check_log("lda_abs_partial", 1, 9'h0AD, 9'h000, 9'h000);
    send(5'b00110, 4'd12, 16'h0005, 1'b0);
    wait_idle();
    check_log("bne_rel", 2, 9'h0D0, 9'h105, 9'h000);

    // randomized requests, gaps, back-pressure and occasional resets
    for (int k = 0; k < 400; k++) begin
      r = $urandom;
      send(r[4:0], r[8:5], r[31:16], 1'b1);
      repeat ($urandom_range(0, 2)) begin
        r = $urandom;
        bus.out_ready = (r[1:0] != 2'b00);
        randomize_dont_care();
        @(negedge clk);
      end
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    bus.out_ready = 1'b1;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/op_encode.md
OP_ENCODE -- requirements
Module: op_encode

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 in_valid  in  1  instruction request present.
REQ-004 in_ready  out  1  encoder can accept a request.
REQ-005 in_mnem  in  5  {grp[1:0], aaa[2:0]}; grp 01 = ALU, 10 = RMW/X, 00 = Y/control, 11 = raw implied byte.
REQ-006 in_mode  in  4  0 IMP, 1 ACC, 2 IMM, 3 ZPG, 4 ZPX, 5 ZPY, 6 ABS, 7 ABX, 8 ABY, 9 IND, 10 XIN, 11 INY, 12 REL; 13-15 illegal.
REQ-007 in_operand  in  16  operand: low byte first, high byte used only for 3-byte forms.
REQ-008 out_valid  out  1  out_byte valid.
REQ-009 out_ready  in  1  downstream accepts out_byte.
REQ-010 out_byte  out  8  opcode or operand byte.
REQ-011 out_last  out  1  out_byte is the final byte of the instruction.
REQ-012 err  out  1  one-cycle pulse: illegal mnem/mode combination rejected.

Function
REQ-013 Encoder SHALL form opcode = {aaa, bbb, grp}; bbb is derived from mode per REQ-014..REQ-017.
REQ-014 grp01 bbb mapping SHALL be: XIN 000, ZPG 001, IMM 010, ABS 011, INY 100, ZPX 101, ABY 110, ABX 111; all other modes are illegal; aaa=100 with IMM is illegal.
REQ-015 grp10 bbb mapping SHALL be: IMM 000 (aaa=101 only), ZPG 001, ACC 010 (aaa<=011 only), ABS 011, ZPX/ZPY 101, ABX/ABY 111.
REQ-016 grp10 indexing rules: ZPY/ABY are legal only for aaa 100/101; ABY is illegal for aaa=100; ZPX/ABX are illegal for aaa 100/101.
REQ-017 grp00: REL SHALL encode {aaa,10000}.
REQ-017a grp00: JMP (aaa=010) ABS SHALL encode 4C and IND SHALL encode 6C.
REQ-017b grp00: BIT (001) is legal for ZPG/ABS; STY (100) for ZPG/ZPX/ABS; LDY (101) for IMM 000/ZPG/ZPX/ABS/ABX; CPY/CPX (110/111) for IMM 000/ZPG/ABS.
REQ-017c All other grp00 combinations are illegal.
REQ-018 grp11 with IMP SHALL emit in_operand[7:0] as a 1-byte instruction; grp11 with any other mode is illegal.
REQ-019 Instruction length SHALL be: IMP/ACC = 1; IMM/ZPG/ZPX/ZPY/XIN/INY/REL = 2; ABS/ABX/ABY/IND = 3.
REQ-020 FSM states SHALL be IDLE, OPC, LO, HI; in_ready=1 only in IDLE.
REQ-021 In IDLE, accepting a legal request (in_valid & in_ready) SHALL latch opcode, operand and length, and move to OPC.
REQ-021a out_valid SHALL assert the cycle after acceptance.
REQ-022 On an accepted illegal request: err=1 for the following cycle, no bytes emitted, FSM stays in IDLE.
REQ-023 A byte transfers when out_valid & out_ready; out_byte SHALL hold stable while out_ready=0.
REQ-023a On transfer, OPC->LO (len>=2) else IDLE; LO->HI (len=3) else IDLE; HI->IDLE.
REQ-024 out_last SHALL be 1 exactly on the final byte of each instruction.
REQ-025 Throughput SHALL be one byte per cycle under continuous out_ready.
REQ-025a The next request SHALL be accepted the cycle after the last transfer (one idle bubble).
REQ-026 Inputs other than in_valid are don't-care when not accepted.

Reset
REQ-027 rst asserted at any time, including mid-instruction, SHALL force IDLE and out_valid=0, out_last=0, err=0, out_byte=00, in_ready=1.
REQ-027a The partial instruction is discarded on reset.

Configuration
REQ-028 ENC_LEGAL_CHECK_EN defined: legality rules REQ-014..REQ-018 SHALL be enforced with err per REQ-022.
REQ-028a ENC_LEGAL_CHECK_EN undefined: err tied 0 and opcode formed from the bbb tables without restriction.
REQ-028b With ENC_LEGAL_CHECK_EN undefined, unmapped modes SHALL give bbb=000 and length 1.

Verification
REQ-029 LDA IMM (mnem 01_101, mode 2, operand 0042), out_ready=1 -> A9, 42; out_last on 42.
REQ-030 STA ABX (01_100, mode 7, 1234) with out_ready low for 3 cycles on second byte -> 9D, 34 (held stable), 12; out_last on 12.
REQ-031 ASL ACC (10_000, mode 1) -> single byte 0A with out_last=1; JMP IND (00_010, mode 9, FFFC) -> 6C, FC, FF.
REQ-032 STA IMM (01_100, mode 2) -> err pulse 1 cycle, out_valid stays 0, in_ready stays 1.
REQ-033 rst pulse after the first byte of LDA ABS (AD) -> out_valid=0 immediately; next request BNE REL (00_110, mode 12, 0005) -> D0, 05.
